// File: rtl/ps2_keyboard_receiver.sv
// rtl/ps2_keyboard_receiver.sv - PS/2 keyboard scan-code receiver with E0/F0 prefix decoding
module ps2_keyboard_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_prev_q;
  logic                  fall;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  e0_q, e0_d, f0_q, f0_d;
  logic [7:0]            code_q, code_d;
  logic                  valid_q, valid_d, rel_q, rel_d, ext_q, ext_d, ferr_q, ferr_d;

  // Synchronize both raw lines into clk; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Sample history including the current synchronized sample.
  always_comb begin
    hist_d    = hist_q << 1;
    hist_d[0] = clk_sync_q;
  end

  // Glitch filter: level changes only after FILTER_LEN equal samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      hist_q      <= hist_d;
      filt_prev_q <= filt_q;
      if (hist_d == '1)      filt_q <= 1'b1;
      else if (hist_d == '0) filt_q <= 1'b0;
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Frame FSM, timeout supervision and scan-code prefix decoding.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = '0;
    e0_d      = e0_q;
    f0_d      = f0_q;
    code_d    = code_q;
    ext_d     = ext_q;
    valid_d   = 1'b0;
    rel_d     = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !data_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_sync_q && (^{shift_q, parity_q})) begin
            case (shift_q)
              8'hE0: e0_d = 1'b1;
              8'hF0: f0_d = 1'b1;
              8'hE1: begin
                e0_d = 1'b0;
                f0_d = 1'b0;
              end
              default: begin
                code_d  = shift_q;
                ext_d   = e0_q;
                rel_d   = f0_q;
                valid_d = ~f0_q;
                e0_d    = 1'b0;
                f0_d    = 1'b0;
              end
            endcase
          end else begin
            ferr_d = 1'b1;
            e0_d   = 1'b0;
            f0_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An abandoned partial frame overrides whatever the case above decided.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
        e0_d    = 1'b0;
        f0_d    = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      e0_q      <= 1'b0;
      f0_q      <= 1'b0;
      code_q    <= 8'h00;
      ext_q     <= 1'b0;
      valid_q   <= 1'b0;
      rel_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      e0_q      <= e0_d;
      f0_q      <= f0_d;
      code_q    <= code_d;
      ext_q     <= ext_d;
      valid_q   <= valid_d;
      rel_q     <= rel_d;
      ferr_q    <= ferr_d;
    end
  end

  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_released = rel_q;
  assign key_extended = ext_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb/tb_ps2_keyboard_receiver.sv - self-checking bench for ps2_keyboard_receiver
module tb_ps2_keyboard_receiver;

  localparam int T  = 200;  // shortened timeout so the bench stays small
  localparam int FL = 4;
  localparam int H  = 20;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid, key_released, key_extended, frame_error;

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(T), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .key_released(key_released),
    .key_extended(key_extended), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // kind: 0 make, 1 break, 2 frame error
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  passed = 0;
  int  total  = 0;
  int  both_cnt = 0;
  bit  m_e0 = 1'b0;
  bit  m_f0 = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (key_valid)    obs_q.push_back({2'd0, key_code, key_extended});
      if (key_released) obs_q.push_back({2'd1, key_code, key_extended});
      if (frame_error)  obs_q.push_back({2'd2, 8'h00, 1'b0});
      if (key_valid && key_released) both_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Keyboard protocol model: what a received byte should produce.
  task automatic model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      e = {2'd2, 8'h00, 1'b0};
      exp_q.push_back(e);
      m_e0 = 1'b0; m_f0 = 1'b0;
    end else if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_f0 = 1'b1;
    else if (b == 8'hE1) begin
      m_e0 = 1'b0; m_f0 = 1'b0;
    end else begin
      e = {(m_f0 ? 2'd1 : 2'd0), b, m_e0};
      exp_q.push_back(e);
      m_e0 = 1'b0; m_f0 = 1'b0;
    end
  endtask

  task automatic send_bit(input logic d);
    @(negedge clk) ps2_data = d;
    repeat (H - 1) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    @(negedge clk) ps2_data = 1'b1;
    repeat (3 * H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b, 1'b1);
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++; if (key_code !== 8'h00) $display("FAIL reset_key_code: got %h expected 00", key_code); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else passed++;
    total++; if (key_released !== 1'b0) $display("FAIL reset_key_released: got %b expected 0", key_released); else passed++;
    total++; if (key_extended !== 1'b0) $display("FAIL reset_key_extended: got %b expected 0", key_extended); else passed++;
    total++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b expected 0", frame_error); else passed++;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_make();
    clear_q();
    send_good(8'h1C);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL make_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL make_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (key_code !== 8'h1C) $display("FAIL make_hold_code: got %h expected 1c", key_code); else passed++;
  endtask

  task automatic test_extended();
    clear_q();
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL ext_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL ext_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (key_extended !== 1'b1) $display("FAIL ext_hold: got %b expected 1", key_extended); else passed++;
  endtask

  task automatic test_parity_error();
    clear_q();
    send_good(8'hE0);
    send_frame(8'h6B, 1'b1, 1'b0);
    model_byte(8'h6B, 1'b0);
    send_good(8'h74);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL parity_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL parity_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_timeout();
    int n;
    int first;
    clear_q();
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk) ps2_data = 1'b0;
    repeat (H - 1) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    first = 0;
    while (n < T + 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == H) ps2_clk = 1'b1;
      if (frame_error && first == 0) first = n;
    end
    ps2_data = 1'b1;
    // Edge reaches the FSM after 2 sync flops, FL filter samples and the edge register.
    total++; if (first !== T + FL + 3) $display("FAIL timeout_latency: got %0d expected %0d", first, T + FL + 3); else passed++;
    model_byte(8'h00, 1'b0);
    repeat (H) @(negedge clk);
    send_good(8'h72);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL timeout_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL timeout_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_glitch();
    clear_q();
    @(negedge clk) ps2_data = 1'b0;
    @(negedge clk) ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (T + 40) @(negedge clk);
    total++; if (obs_q.size() !== 0) $display("FAIL glitch_short_events: got %0d expected 0", obs_q.size()); else passed++;
    total++; if (key_code !== 8'h72) $display("FAIL glitch_code: got %h expected 72", key_code); else passed++;
    // A pulse of exactly FL samples must pass and start a frame that later times out.
    ps2_clk = 1'b0;
    repeat (FL) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (T + 40) @(negedge clk);
    ps2_data = 1'b1;
    model_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL glitch_pass_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL glitch_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    send_good(8'hE0); send_good(8'h75);
    clear_q();
    b = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    @(negedge clk) rst_n = 1'b0;
    #1;
    total++; if (key_code !== 8'h00) $display("FAIL midrst_code: got %h expected 00", key_code); else passed++;
    total++; if (key_extended !== 1'b0) $display("FAIL midrst_ext: got %b expected 0", key_extended); else passed++;
    total++; if ({key_valid, key_released, frame_error} !== 3'b000) $display("FAIL midrst_pulses: got %b expected 000", {key_valid, key_released, frame_error}); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_e0 = 1'b0; m_f0 = 1'b0;
    repeat (T + 40) @(negedge clk);
    total++; if (obs_q.size() !== 0) $display("FAIL midrst_no_pulse: got %0d expected 0", obs_q.size()); else passed++;
    send_good(8'h75);
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL midrst_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    bit bp, bs;
    clear_q();
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      bp = (r == 0);
      bs = (r == 1);
      send_frame(b, bp, bs);
      model_byte(b, !(bp || bs));
    end
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL random_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (both_cnt !== 0) $display("FAIL valid_and_released_together: got %0d expected 0", both_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_make();
    test_extended();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
